// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and helpers for the elastic pipeline register family.
//   MAX_DEPTH      : largest supported number of register stages
//   RESET_DATA_ON  : data registers are loaded with RESET_VAL by reset
//   RESET_DATA_OFF : data registers are left unreset (only valid bits clear)
//   cnt_w(depth)   : occupancy counter width, max(1, clog2(depth+1))
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int unsigned MAX_DEPTH      = 32'd8;
   localparam bit          RESET_DATA_ON  = 1'b1;
   localparam bit          RESET_DATA_OFF = 1'b0;

   function automatic int unsigned cnt_w(input int unsigned depth);
      int unsigned w;
      w = $clog2(depth + 32'd1);
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
// Ports:
//   CLK      in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   flush_i  in   synchronous clear of the valid bit (data holds)
//   load_i   in   stage takes the source valid (and data, if source valid)
//   v_i      in   source valid
//   d_i      in   source data
//   v_o      out  stage valid
//   d_o      out  stage data
// -----------------------------------------------------------------------------
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH      = 18,
   parameter bit               RESET_DATA = RESET_DATA_ON,
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             load_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             v_o,
   output logic [WIDTH-1:0] d_o
);

   logic             v_q;
   logic [WIDTH-1:0] d_q;

   // Valid bit: flush beats load; load copies the source valid (bubbles included).
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         v_q <= 1'b0;
      end else if (flush_i) begin
         v_q <= 1'b0;
      end else if (load_i) begin
         v_q <= v_i;
      end else begin
         v_q <= v_q;
      end
   end

   // Data is only captured for real words so bubbles cause no data toggling.
   if (RESET_DATA) begin : g_data_rst
      // Data register cleared to RESET_VAL by reset.
      always_ff @(posedge CLK or posedge reset) begin
         if (reset) begin
            d_q <= RESET_VAL;
         end else if (load_i && v_i) begin
            d_q <= d_i;
         end else begin
            d_q <= d_q;
         end
      end
   end else begin : g_data_norst
      // Data register without reset.
      always_ff @(posedge CLK) begin
         if (load_i && v_i) begin
            d_q <= d_i;
         end else begin
            d_q <= d_q;
         end
      end
   end

   assign v_o = v_q;
   assign d_o = d_q;

endmodule

// File: rtl/pipe_reg_elastic.sv
// -----------------------------------------------------------------------------
// pipe_reg_elastic
// DEPTH-stage elastic pipeline register with valid/ready on both sides,
// global clock enable, synchronous flush and occupancy reporting.
// DEPTH=0 is a pure wire bypass (no registers, ce/flush ignored).
// DEPTH must be in 0..MAX_DEPTH.
// Ports:
//   CLK        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   ce         in   clock enable; 0 freezes all stage state
//   flush      in   synchronous clear of all valid bits
//   in_valid   in   upstream data valid
//   in_ready   out  in_data is accepted this cycle
//   in_data    in   upstream data
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   out_data   out  data from the last stage
//   occupancy  out  number of valid stages
// -----------------------------------------------------------------------------
module pipe_reg_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH      = 18,
   parameter int unsigned      DEPTH      = 1,
   parameter bit               RESET_DATA = RESET_DATA_ON,
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    ce,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [cnt_w(DEPTH)-1:0] occupancy
);

   localparam int unsigned CNT_W = cnt_w(DEPTH);

   if (DEPTH == 0) begin : g_bypass
      logic unused_s;

      assign out_data  = in_data;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign occupancy = {CNT_W{1'b0}};
      assign unused_s  = ^{CLK, reset, ce, flush};
   end else begin : g_pipe
      logic [DEPTH-1:0] v_s;
      logic [WIDTH-1:0] d_s [DEPTH];
      logic [DEPTH-1:0] rdy_s;
      logic [CNT_W-1:0] occ_q;
      logic [CNT_W-1:0] occ_d;
      logic             push_s;
      logic             pop_s;

      // Ready chain from the output back to the input: a stage can load when it
      // is empty or its word moves on this cycle.
      always_comb begin
         logic r;
         r     = out_ready;
         rdy_s = {DEPTH{1'b0}};
         for (int k = DEPTH - 1; k >= 0; k--) begin
            r        = ce & ~flush & (~v_s[k] | r);
            rdy_s[k] = r;
         end
      end

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         if (k == 0) begin : g_first
            pipe_stage #(
               .WIDTH      (WIDTH),
               .RESET_DATA (RESET_DATA),
               .RESET_VAL  (RESET_VAL)
            ) u_stage (
               .CLK     (CLK),
               .reset   (reset),
               .flush_i (flush),
               .load_i  (rdy_s[k]),
               .v_i     (in_valid),
               .d_i     (in_data),
               .v_o     (v_s[k]),
               .d_o     (d_s[k])
            );
         end else begin : g_next
            pipe_stage #(
               .WIDTH      (WIDTH),
               .RESET_DATA (RESET_DATA),
               .RESET_VAL  (RESET_VAL)
            ) u_stage (
               .CLK     (CLK),
               .reset   (reset),
               .flush_i (flush),
               .load_i  (rdy_s[k]),
               .v_i     (v_s[k-1]),
               .d_i     (d_s[k-1]),
               .v_o     (v_s[k]),
               .d_o     (d_s[k])
            );
         end
      end

      assign in_ready  = rdy_s[0];
      assign out_valid = v_s[DEPTH-1] & ce & ~flush;
      assign out_data  = d_s[DEPTH-1];
      assign push_s    = in_valid & rdy_s[0];
      assign pop_s     = out_valid & out_ready;

      // Occupancy next state: flush clears, push/pop step, both together cancel.
      always_comb begin
         occ_d = occ_q;
         if (flush) begin
            occ_d = {CNT_W{1'b0}};
         end else if (push_s && !pop_s) begin
            occ_d = occ_q + CNT_W'(1);
         end else if (!push_s && pop_s) begin
            occ_d = occ_q - CNT_W'(1);
         end else begin
            occ_d = occ_q;
         end
      end

      // Occupancy register.
      always_ff @(posedge CLK or posedge reset) begin
         if (reset) begin
            occ_q <= {CNT_W{1'b0}};
         end else begin
            occ_q <= occ_d;
         end
      end

      assign occupancy = occ_q;
   end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
module tb_pipe_reg_elastic;

   localparam int W = 18;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   // index 0: DEPTH=3, RESET_VAL=0x2A; index 1: DEPTH=2, data not reset
   logic         ce [2];
   logic         flush [2];
   logic         in_valid [2];
   logic         in_ready [2];
   logic         out_valid [2];
   logic         out_ready [2];
   logic [W-1:0] in_data [2];
   logic [W-1:0] out_data [2];
   logic [1:0]   occ [2];

   logic         bp_ce, bp_flush, bp_iv, bp_ir, bp_ov, bp_or;
   logic [W-1:0] bp_id, bp_od;
   logic [0:0]   bp_occ;

   pipe_reg_elastic #(.WIDTH(W), .DEPTH(3), .RESET_DATA(1'b1), .RESET_VAL(18'h0002A)) u_d3 (
      .CLK(CLK), .reset(reset), .ce(ce[0]), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .occupancy(occ[0]));

   pipe_reg_elastic #(.WIDTH(W), .DEPTH(2), .RESET_DATA(1'b0)) u_d2 (
      .CLK(CLK), .reset(reset), .ce(ce[1]), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .occupancy(occ[1]));

   pipe_reg_elastic #(.WIDTH(W), .DEPTH(0)) u_d0 (
      .CLK(CLK), .reset(reset), .ce(bp_ce), .flush(bp_flush),
      .in_valid(bp_iv), .in_ready(bp_ir), .in_data(bp_id),
      .out_valid(bp_ov), .out_ready(bp_or), .out_data(bp_od),
      .occupancy(bp_occ));

   int checks = 0;
   int errors = 0;

   // Reference model: words in flight, oldest first, each with its stage index.
   int           dep [2] = '{3, 2};
   int           mn [2];
   int           mp [2][4];
   logic [W-1:0] md [2][4];
   int           nx [2][4];

   logic         obs_ov [2];
   logic         obs_ir [2];
   logic [W-1:0] obs_od [2];
   logic [1:0]   obs_occ [2];

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Oldest word leaves from the last stage if out_ready; every other word
   // advances one stage when the slot ahead is free after the older words moved.
   task automatic predict(input int u, output bit ev, output bit eir, output logic [W-1:0] ed);
      int lim;
      bit live;
      live = (ce[u] === 1'b1) && (flush[u] === 1'b0);
      ev   = live && (mn[u] > 0) && (mp[u][0] == dep[u] - 1);
      ed   = md[u][0];
      lim  = dep[u];
      for (int i = 0; i < mn[u]; i++) begin
         if (!live) nx[u][i] = mp[u][i];
         else if (mp[u][i] == dep[u] - 1) nx[u][i] = out_ready[u] ? -1 : mp[u][i];
         else nx[u][i] = (mp[u][i] + 1 < lim) ? mp[u][i] + 1 : mp[u][i];
         if (nx[u][i] >= 0) lim = nx[u][i];
      end
      eir = live && (mn[u] == 0 || nx[u][mn[u] - 1] != 0);
   endtask

   task automatic commit(input int u, input bit eir);
      int k = 0;
      if (flush[u]) begin
         mn[u] = 0;
      end else if (ce[u]) begin
         for (int i = 0; i < mn[u]; i++) begin
            if (nx[u][i] >= 0) begin
               mp[u][k] = nx[u][i];
               md[u][k] = md[u][i];
               k++;
            end
         end
         mn[u] = k;
         if (in_valid[u] && eir) begin
            mp[u][k] = 0;
            md[u][k] = in_data[u];
            mn[u]    = k + 1;
         end
      end
   endtask

   // Called at posedge+1 with inputs already set; returns at the next posedge+1.
   task automatic cycle();
      bit           ev [2];
      bit           eir [2];
      logic [W-1:0] ed [2];
      #3;
      for (int u = 0; u < 2; u++) begin
         predict(u, ev[u], eir[u], ed[u]);
         check_value($sformatf("d%0d_out_valid", u), 32'(out_valid[u]), 32'(ev[u]));
         check_value($sformatf("d%0d_in_ready", u), 32'(in_ready[u]), 32'(eir[u]));
         check_value($sformatf("d%0d_occupancy", u), 32'(occ[u]), 32'(mn[u]));
         if (ev[u]) check_value($sformatf("d%0d_out_data", u), 32'(out_data[u]), 32'(ed[u]));
         obs_ov[u]  = out_valid[u];
         obs_ir[u]  = in_ready[u];
         obs_od[u]  = out_data[u];
         obs_occ[u] = occ[u];
      end
      check_value("bp_out_data", 32'(bp_od), 32'(bp_id));
      check_value("bp_out_valid", 32'(bp_ov), 32'(bp_iv));
      check_value("bp_in_ready", 32'(bp_ir), 32'(bp_or));
      check_value("bp_occupancy", 32'(bp_occ), 32'd0);
      @(posedge CLK);
      #1;
      for (int u = 0; u < 2; u++) commit(u, eir[u]);
   endtask

   task automatic drive(input int u, input logic c, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
      ce[u]        = c;
      flush[u]     = f;
      in_valid[u]  = iv;
      in_data[u]   = d;
      out_ready[u] = ordy;
   endtask

   initial begin
      int first;
      int outs;
      int peak;
      logic [W-1:0] exp_seq [3];

      reset = 1'b0;
      for (int u = 0; u < 2; u++) begin
         drive(u, 1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
         mn[u] = 0;
      end
      bp_ce = 1'b0; bp_flush = 1'b1; bp_iv = 1'b1; bp_id = 18'h15A5A; bp_or = 1'b0;

      // Async reset before any clock edge
      #1 reset = 1'b1;
      #1;
      check_value("rst_d3_out_valid", 32'(out_valid[0]), 32'd0);
      check_value("rst_d3_occupancy", 32'(occ[0]), 32'd0);
      check_value("rst_d3_out_data", 32'(out_data[0]), 32'h2A);
      check_value("rst_d2_occupancy", 32'(occ[1]), 32'd0);
      check_value("rst_bp_out_data", 32'(bp_od), 32'h15A5A);
      @(posedge CLK);
      #1 reset = 1'b0;

      // Back-to-back stream of 1..5 through DEPTH=3
      first = -1; outs = 0; peak = 0;
      for (int c = 0; c < 12; c++) begin
         drive(0, 1'b1, 1'b0, (c < 5), W'(c + 1), 1'b1);
         cycle();
         if (obs_ov[0]) begin
            if (first < 0) first = c;
            check_value("t1_order", 32'(obs_od[0]), 32'(outs + 1));
            outs++;
         end
         if (int'(obs_occ[0]) > peak) peak = int'(obs_occ[0]);
      end
      check_value("t1_first_valid_cycle", 32'(first), 32'd3);
      check_value("t1_output_count", 32'(outs), 32'd5);
      check_value("t1_peak_occupancy", 32'(peak), 32'd3);

      // Fill A,B,C then stall 4 cycles, then drain
      exp_seq = '{18'h0001A, 18'h0001B, 18'h0001C};
      for (int c = 0; c < 3; c++) begin
         drive(0, 1'b1, 1'b0, 1'b1, exp_seq[c], 1'b0);
         cycle();
      end
      for (int c = 0; c < 4; c++) begin
         drive(0, 1'b1, 1'b0, 1'b1, 18'h3FFFF, 1'b0);
         cycle();
         check_value("t2_stall_in_ready", 32'(obs_ir[0]), 32'd0);
         check_value("t2_stall_occupancy", 32'(obs_occ[0]), 32'd3);
         check_value("t2_stall_out_data", 32'(obs_od[0]), 32'h1A);
      end
      for (int c = 0; c < 3; c++) begin
         drive(0, 1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
         cycle();
         check_value("t2_drain_valid", 32'(obs_ov[0]), 32'd1);
         check_value("t2_drain_data", 32'(obs_od[0]), 32'(exp_seq[c]));
      end

      // One word parked in S2, downstream stalled, two more words collapse in
      drive(0, 1'b1, 1'b0, 1'b1, 18'h00003, 1'b0);
      cycle();
      for (int c = 0; c < 2; c++) begin
         drive(0, 1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
         cycle();
      end
      for (int c = 0; c < 2; c++) begin
         drive(0, 1'b1, 1'b0, 1'b1, W'(18'h00010 + c), 1'b0);
         cycle();
         check_value("t3_bubble_accept", 32'(obs_ir[0]), 32'd1);
      end
      drive(0, 1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
      cycle();
      check_value("t3_occupancy", 32'(obs_occ[0]), 32'd3);
      for (int c = 0; c < 4; c++) begin
         drive(0, 1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
         cycle();
      end

      // DEPTH=2 full, then flush with in_valid high
      for (int c = 0; c < 2; c++) begin
         drive(1, 1'b1, 1'b0, 1'b1, W'(18'h00200 + c), 1'b0);
         cycle();
      end
      drive(1, 1'b1, 1'b1, 1'b1, 18'h00333, 1'b1);
      cycle();
      check_value("t4_flush_in_ready", 32'(obs_ir[1]), 32'd0);
      check_value("t4_flush_out_valid", 32'(obs_ov[1]), 32'd0);
      drive(1, 1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
      cycle();
      check_value("t4_post_flush_occupancy", 32'(obs_occ[1]), 32'd0);

      // DEPTH=2 streaming with ce 1,0,0,1
      for (int c = 0; c < 10; c++) begin
         drive(1, !(c == 1 || c == 2), 1'b0, 1'b1, W'(18'h00100 + c), 1'b1);
         cycle();
      end

      // Random traffic on all three instances, with a mid-stream reset pulse
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < 2; u++) begin
            drive(u, ($urandom_range(7, 0) != 0), ($urandom_range(19, 0) == 0),
                  ($urandom_range(9, 0) < 7), W'($urandom), ($urandom_range(9, 0) < 6));
         end
         bp_ce = 1'($urandom); bp_flush = 1'($urandom); bp_iv = 1'($urandom);
         bp_or = 1'($urandom); bp_id = W'($urandom);
         if (c == 200) begin
            reset = 1'b1;
            #1;
            check_value("t6_out_valid", 32'(out_valid[0]), 32'd0);
            check_value("t6_occupancy", 32'(occ[0]), 32'd0);
            check_value("t6_out_data", 32'(out_data[0]), 32'h2A);
            check_value("t6_d2_out_valid", 32'(out_valid[1]), 32'd0);
            check_value("t6_d2_occupancy", 32'(occ[1]), 32'd0);
            mn[0] = 0;
            mn[1] = 0;
            @(posedge CLK);
            #1 reset = 1'b0;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
